// File: rtl/execute_multiply_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : execute_multiply_unit_if
// Description : Bundle between the decode/execute pipeline register and the
//               iterative multiply unit.
//               master : pipeline side, drives the operation and flush, and
//                        receives stall and result.
//               slave  : multiply unit.
//               Members: start_i, accumulate_en_i, update_flag_i, operand_a_i,
//                        operand_b_i, accumulator_i, dest_addr_i, flush_i
//                        (towards the unit); stall_o, busy_o, result_valid_o,
//                        result_o, dest_addr_o, flag_update_o, flag_n_o,
//                        flag_z_o (from the unit).
// Revision    : 1.0 - initial release
// ============================================================================
interface execute_multiply_unit_if #(
   parameter int WORD       = 32,
   parameter int ADDR_WIDTH = 4
);
   logic                  start_i;
   logic                  accumulate_en_i;
   logic                  update_flag_i;
   logic [WORD-1:0]       operand_a_i;
   logic [WORD-1:0]       operand_b_i;
   logic [WORD-1:0]       accumulator_i;
   logic [ADDR_WIDTH-1:0] dest_addr_i;
   logic                  flush_i;
   logic                  stall_o;
   logic                  busy_o;
   logic                  result_valid_o;
   logic [WORD-1:0]       result_o;
   logic [ADDR_WIDTH-1:0] dest_addr_o;
   logic                  flag_update_o;
   logic                  flag_n_o;
   logic                  flag_z_o;

   modport master (
      output start_i, accumulate_en_i, update_flag_i, operand_a_i, operand_b_i,
             accumulator_i, dest_addr_i, flush_i,
      input  stall_o, busy_o, result_valid_o, result_o, dest_addr_o,
             flag_update_o, flag_n_o, flag_z_o
   );

   modport slave (
      input  start_i, accumulate_en_i, update_flag_i, operand_a_i, operand_b_i,
             accumulator_i, dest_addr_i, flush_i,
      output stall_o, busy_o, result_valid_o, result_o, dest_addr_o,
             flag_update_o, flag_n_o, flag_z_o
   );
endinterface
`default_nettype wire

// File: rtl/execute_multiply_unit.sv
`default_nettype none
// ============================================================================
// Module      : execute_multiply_unit
// Description : Iterative MUL/MLA engine for the execute stage. Retires
//               BITS_PER_CYCLE multiplier bits per cycle with a fixed latency
//               of WORD/BITS_PER_CYCLE + 1 cycles from acceptance to the
//               single-cycle result beat. Stalls the front end while working.
// Ports       : clk_i    - clock, all state updates on the rising edge
//               reset_i  - synchronous active-high reset
//               bus      - execute_multiply_unit_if.slave (operation in,
//                          stall/busy, result beat with dest and N/Z flags)
// Revision    : 1.0 - initial release
// ============================================================================
module execute_multiply_unit #(
   parameter int WORD           = 32,
   parameter int BITS_PER_CYCLE = 1,
   parameter int ADDR_WIDTH     = 4
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   execute_multiply_unit_if.slave   bus
);

   localparam int c_N_ITER = WORD / BITS_PER_CYCLE;
   localparam int c_CNT_W  = $clog2(c_N_ITER + 1);
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_N_ITER - 1);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_CALC = 2'd1;
   localparam logic [1:0] c_DONE = 2'd2;

   logic [1:0]            r_state;
   logic [1:0]            w_state_next;

   logic [WORD-1:0]       r_a;
   logic [WORD-1:0]       r_b;
   logic [WORD-1:0]       r_product;
   logic [c_CNT_W-1:0]    r_iter;
   logic [ADDR_WIDTH-1:0] r_dest;
   logic                  r_upd;

   // Result-side copies: these only change on the final CALC cycle so the
   // outputs hold while the next operation reloads the working registers.
   logic [WORD-1:0]       r_result;
   logic [ADDR_WIDTH-1:0] r_dest_out;
   logic                  r_upd_out;
   logic                  r_flag_n;
   logic                  r_flag_z;

   logic [WORD-1:0]       w_partial;
   logic [WORD-1:0]       w_sum;
   logic                  w_accept;
   logic                  w_finish;
   logic                  w_stall;
   logic                  w_busy;
   logic                  w_valid;

   // a * b[BITS_PER_CYCLE-1:0] as a sum of shifted multiplicands
   always_comb begin
      w_partial = '0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (r_b[i]) begin
            w_partial = w_partial + (r_a << i);
         end
      end
      w_sum = r_product + w_partial;
   end

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      w_state_next = r_state;
      if (bus.flush_i) begin
         w_state_next = c_IDLE;
      end else begin
         case (r_state)
            c_IDLE:  if (bus.start_i) w_state_next = c_CALC;
            c_CALC:  if (r_iter == c_LAST) w_state_next = c_DONE;
            // The instruction is still held in the pipeline register during
            // DONE, so start_i is ignored here to avoid a restart.
            c_DONE:  w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      w_accept = (r_state == c_IDLE) && bus.start_i && !bus.flush_i;
      w_finish = (r_state == c_CALC) && (r_iter == c_LAST) && !bus.flush_i;
      w_stall  = w_accept || (r_state == c_CALC);
      w_busy   = (r_state != c_IDLE);
      // A flush arriving in DONE kills the op, so the beat is suppressed too.
      w_valid  = (r_state == c_DONE) && !bus.flush_i;
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_a        <= '0;
         r_b        <= '0;
         r_product  <= '0;
         r_iter     <= '0;
         r_dest     <= '0;
         r_upd      <= 1'b0;
         r_result   <= '0;
         r_dest_out <= '0;
         r_upd_out  <= 1'b0;
         r_flag_n   <= 1'b0;
         r_flag_z   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_a       <= bus.operand_a_i;
            r_b       <= bus.operand_b_i;
            r_product <= bus.accumulate_en_i ? bus.accumulator_i : '0;
            r_iter    <= '0;
            r_dest    <= bus.dest_addr_i;
            r_upd     <= bus.update_flag_i;
         end else if (r_state == c_CALC) begin
            r_product <= w_sum;
            r_a       <= r_a << BITS_PER_CYCLE;
            r_b       <= r_b >> BITS_PER_CYCLE;
            r_iter    <= r_iter + c_CNT_W'(1);
         end

         if (w_finish) begin
            r_result   <= w_sum;
            r_dest_out <= r_dest;
            r_upd_out  <= r_upd;
            r_flag_n   <= w_sum[WORD-1];
            r_flag_z   <= (w_sum == '0);
         end
      end
   end

   assign bus.stall_o        = w_stall;
   assign bus.busy_o         = w_busy;
   assign bus.result_valid_o = w_valid;
   assign bus.result_o       = r_result;
   assign bus.dest_addr_o    = r_dest_out;
   assign bus.flag_update_o  = r_upd_out && w_valid;
   assign bus.flag_n_o       = r_flag_n;
   assign bus.flag_z_o       = r_flag_z;

endmodule
`default_nettype wire

// File: tb/tb_execute_multiply_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_multiply_unit
// Description : Scoreboard bench for execute_multiply_unit. Two instances:
//               u1 with one bit per cycle, u2 with four bits per cycle.
//               Stimulus pushes expected beats (cycle, result, dest, flags);
//               per-instance monitors pop and compare on every valid beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_multiply_unit;

   localparam int N1 = 32;
   localparam int N2 = 8;

   typedef struct {
      int          cyc;
      logic [31:0] res;
      logic [3:0]  dest;
      logic        upd;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   pulses1 = 0;
   int   pushes1 = 0;
   int   pulses2 = 0;
   int   pushes2 = 0;
   exp_t q1[$];
   exp_t q2[$];
   exp_t e1;
   exp_t e2;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   execute_multiply_unit_if #(.WORD(32), .ADDR_WIDTH(4)) bus1 ();
   execute_multiply_unit_if #(.WORD(32), .ADDR_WIDTH(4)) bus2 ();

   execute_multiply_unit #(.WORD(32), .BITS_PER_CYCLE(1), .ADDR_WIDTH(4)) u1 (
      .clk_i   (clk),
      .reset_i (rst),
      .bus     (bus1)
   );

   execute_multiply_unit #(.WORD(32), .BITS_PER_CYCLE(4), .ADDR_WIDTH(4)) u2 (
      .clk_i   (clk),
      .reset_i (rst),
      .bus     (bus2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op1(input logic [31:0] a, input logic [31:0] b, input logic [31:0] acc,
                          input logic en, input logic upd, input logic [3:0] dest);
      bus1.start_i         = 1'b1;
      bus1.flush_i         = 1'b0;
      bus1.operand_a_i     = a;
      bus1.operand_b_i     = b;
      bus1.accumulator_i   = acc;
      bus1.accumulate_en_i = en;
      bus1.update_flag_i   = upd;
      bus1.dest_addr_i     = dest;
   endtask

   task automatic push1(input logic [31:0] res, input logic [3:0] dest, input logic upd, input int lat);
      exp_t e;
      e.cyc = cyc + lat; e.res = res; e.dest = dest; e.upd = upd;
      q1.push_back(e);
      pushes1++;
   endtask

   task automatic push2(input logic [31:0] res, input logic [3:0] dest, input logic upd, input int lat);
      exp_t e;
      e.cyc = cyc + lat; e.res = res; e.dest = dest; e.upd = upd;
      q2.push_back(e);
      pushes2++;
   endtask

   task automatic drain();
      for (int k = 0; k < 200 && (q1.size() != 0 || q2.size() != 0); k++) step();
      checks++;
      if (q1.size() != 0 || q2.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout actual_pending=%0d required_pending=0", q1.size() + q2.size());
         q1.delete();
         q2.delete();
      end
      step();
      step();
   endtask

   // ---------------------------------------------------------------- monitors
   always @(negedge clk) begin
      if (!rst && bus1.result_valid_o === 1'b1) begin
         pulses1++;
         if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL u1_unexpected_valid cyc=%0d actual_result=0x%08h required=no_beat", cyc, bus1.result_o);
         end else begin
            e1 = q1.pop_front();
            chk("u1_latency_cycle", cyc, e1.cyc);
            chk("u1_result", bus1.result_o, e1.res);
            chk("u1_dest", {28'd0, bus1.dest_addr_o}, {28'd0, e1.dest});
            chk("u1_flag_n", {31'd0, bus1.flag_n_o}, {31'd0, e1.res[31]});
            chk("u1_flag_z", {31'd0, bus1.flag_z_o}, {31'd0, (e1.res == 32'd0)});
            chk("u1_flag_update", {31'd0, bus1.flag_update_o}, {31'd0, e1.upd});
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && bus2.result_valid_o === 1'b1) begin
         pulses2++;
         if (q2.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL u2_unexpected_valid cyc=%0d actual_result=0x%08h required=no_beat", cyc, bus2.result_o);
         end else begin
            e2 = q2.pop_front();
            chk("u2_latency_cycle", cyc, e2.cyc);
            chk("u2_result", bus2.result_o, e2.res);
            chk("u2_dest", {28'd0, bus2.dest_addr_o}, {28'd0, e2.dest});
         end
      end
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      int p0;
      bus1.start_i = 1'b0; bus1.flush_i = 1'b0; bus1.operand_a_i = '0; bus1.operand_b_i = '0;
      bus1.accumulator_i = '0; bus1.accumulate_en_i = 1'b0; bus1.update_flag_i = 1'b0; bus1.dest_addr_i = '0;
      bus2.start_i = 1'b0; bus2.flush_i = 1'b0; bus2.operand_a_i = '0; bus2.operand_b_i = '0;
      bus2.accumulator_i = '0; bus2.accumulate_en_i = 1'b0; bus2.update_flag_i = 1'b0; bus2.dest_addr_i = '0;

      // reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_result", bus1.result_o, 32'd0);
      chk("rst_dest", {28'd0, bus1.dest_addr_o}, 32'd0);
      chk("rst_valid", {31'd0, bus1.result_valid_o}, 32'd0);
      chk("rst_busy", {31'd0, bus1.busy_o}, 32'd0);
      chk("rst_stall", {31'd0, bus1.stall_o}, 32'd0);
      chk("rst_flags", {29'd0, bus1.flag_update_o, bus1.flag_n_o, bus1.flag_z_o}, 32'd0);
      chk("rst_u2_busy_valid", {30'd0, bus2.busy_o, bus2.result_valid_o}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      step();

      // 1: MUL 3*5, stall high T..T+32, low in DONE
      set_op1(32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 4'd2);
      push1(32'd15, 4'd2, 1'b0, N1 + 1);
      @(negedge clk);
      chk("t1_stall_accept", {31'd0, bus1.stall_o}, 32'd1);
      step();
      bus1.start_i = 1'b0;
      for (int k = 1; k <= N1; k++) begin
         @(negedge clk);
         chk("t1_stall_calc", {30'd0, bus1.stall_o, bus1.busy_o}, 32'd3);
         step();
      end
      @(negedge clk);
      chk("t1_stall_done", {30'd0, bus1.stall_o, bus1.busy_o}, 32'd1);
      step();
      @(negedge clk);
      chk("t1_idle_after", {31'd0, bus1.busy_o}, 32'd0);
      step();

      // 2: MLA 7*6+100, dest 4
      set_op1(32'd7, 32'd6, 32'd100, 1'b1, 1'b0, 4'd4);
      push1(32'd142, 4'd4, 1'b0, N1 + 1);
      step(); bus1.start_i = 1'b0;
      drain();

      // 3: 0xFFFFFFFF*2 with flag update
      set_op1(32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 1'b1, 4'd7);
      push1(32'hFFFF_FFFE, 4'd7, 1'b1, N1 + 1);
      step(); bus1.start_i = 1'b0;
      drain();

      // 4: wrap to zero, then 0*x with zero accumulator
      set_op1(32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 1'b1, 4'd1);
      push1(32'd0, 4'd1, 1'b1, N1 + 1);
      step(); bus1.start_i = 1'b0;
      drain();
      set_op1(32'd0, 32'h0000_1234, 32'd0, 1'b1, 1'b1, 4'd3);
      push1(32'd0, 4'd3, 1'b1, N1 + 1);
      step(); bus1.start_i = 1'b0;
      drain();

      // signed operand: -3 * 5 = -15
      set_op1(32'hFFFF_FFFD, 32'd5, 32'd0, 1'b0, 1'b1, 4'd9);
      push1(32'hFFFF_FFF1, 4'd9, 1'b1, N1 + 1);
      step(); bus1.start_i = 1'b0;
      drain();

      // 5: flush at T+10, new op at T+12 completes at T+45
      set_op1(32'd11, 32'd13, 32'd0, 1'b0, 1'b0, 4'd5);
      step(); bus1.start_i = 1'b0;
      repeat (9) step();
      bus1.flush_i = 1'b1;
      step();
      bus1.flush_i = 1'b0;
      @(negedge clk);
      chk("t5_flush_idle", {30'd0, bus1.stall_o, bus1.busy_o}, 32'd0);
      step();
      set_op1(32'd9, 32'd9, 32'd0, 1'b0, 1'b0, 4'd6);
      push1(32'd81, 4'd6, 1'b0, N1 + 1);
      step(); bus1.start_i = 1'b0;
      drain();

      // flush has priority over start in IDLE
      set_op1(32'd2, 32'd2, 32'd0, 1'b0, 1'b0, 4'd8);
      bus1.flush_i = 1'b1;
      @(negedge clk);
      chk("flush_prio_stall", {31'd0, bus1.stall_o}, 32'd0);
      step();
      bus1.start_i = 1'b0;
      bus1.flush_i = 1'b0;
      @(negedge clk);
      chk("flush_prio_busy", {31'd0, bus1.busy_o}, 32'd0);
      step();

      // 6: start held through DONE, new op in the following cycle
      p0 = pulses1;
      set_op1(32'd4, 32'd5, 32'd0, 1'b0, 1'b0, 4'd10);
      push1(32'd20, 4'd10, 1'b0, N1 + 1);
      repeat (N1 + 2) step();
      set_op1(32'd6, 32'd8, 32'd1, 1'b1, 1'b0, 4'd11);
      push1(32'd49, 4'd11, 1'b0, N1 + 1);
      step(); bus1.start_i = 1'b0;
      drain();
      chk("t6_pulse_count", pulses1 - p0, 32'd2);

      // 6b: four bits per cycle, valid at T+9
      bus2.start_i = 1'b1; bus2.operand_a_i = 32'd3; bus2.operand_b_i = 32'd5;
      bus2.accumulate_en_i = 1'b0; bus2.accumulator_i = 32'd0; bus2.dest_addr_i = 4'd2;
      push2(32'd15, 4'd2, 1'b0, N2 + 1);
      step(); bus2.start_i = 1'b0;
      drain();
      bus2.start_i = 1'b1; bus2.operand_a_i = 32'd7; bus2.operand_b_i = 32'd6;
      bus2.accumulate_en_i = 1'b1; bus2.accumulator_i = 32'd100; bus2.dest_addr_i = 4'd4;
      push2(32'd142, 4'd4, 1'b0, N2 + 1);
      step(); bus2.start_i = 1'b0;
      drain();

      chk("u1_total_beats", pulses1, pushes1);
      chk("u2_total_beats", pulses2, pushes2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
